// File: rtl/mc_pkg.sv
// Shared constants, state encoding and control bundle for the multi-cycle
// MIPS-subset controller (optional illegal-opcode trap: MC_ILLEGAL_TRAP_EN).
package mc_pkg;

   localparam logic [5:0] OP_R    = 6'h00;
   localparam logic [5:0] OP_ADDI = 6'h08;
   localparam logic [5:0] OP_SLTI = 6'h0A;
   localparam logic [5:0] OP_LW   = 6'h23;
   localparam logic [5:0] OP_SW   = 6'h2B;
   localparam logic [5:0] OP_BEQ  = 6'h04;

   localparam logic [3:0] S_IF    = 4'd0;
   localparam logic [3:0] S_ID    = 4'd1;
   localparam logic [3:0] S_EX_R  = 4'd2;
   localparam logic [3:0] S_EX_I  = 4'd3;
   localparam logic [3:0] S_MADDR = 4'd4;
   localparam logic [3:0] S_MRD   = 4'd5;
   localparam logic [3:0] S_MWR   = 4'd6;
   localparam logic [3:0] S_WB_R  = 4'd7;
   localparam logic [3:0] S_WB_I  = 4'd8;
   localparam logic [3:0] S_WB_M  = 4'd9;
   localparam logic [3:0] S_BR    = 4'd10;
   localparam logic [3:0] S_TRAP  = 4'd11;

   localparam logic [1:0] ALU_OP_ADD   = 2'b00;
   localparam logic [1:0] ALU_OP_SUB   = 2'b01;
   localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
   localparam logic [1:0] ALU_OP_SLT   = 2'b11;

   localparam logic [1:0] SRCB_B       = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       pc_source;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       retire;
   } ctrl_t;

   function automatic logic is_known_op(input logic [5:0] op);
      return (op == OP_R) || (op == OP_ADDI) || (op == OP_SLTI) ||
             (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ);
   endfunction

endpackage

// File: rtl/mc_out_decode.sv
// Combinational state -> datapath control table. Only IF (fetch strobes)
// and MWR (retire) look at mem_ready_i; ID retires when an unknown opcode is a NOP.
module mc_out_decode
   import mc_pkg::*;
(
   input  logic [3:0] state_i,
   input  logic       mem_ready_i,
   input  logic       slti_i,
   input  logic       nop_i,
   output ctrl_t      ctrl_o
);

   always_comb begin
      ctrl_o = '0;
      case (state_i)
         S_IF: begin
            ctrl_o.mem_read  = 1'b1;
            ctrl_o.alu_src_b = SRCB_FOUR;
            ctrl_o.alu_op    = ALU_OP_ADD;
            ctrl_o.ir_write  = mem_ready_i;
            ctrl_o.pc_write  = mem_ready_i;
         end
         S_ID: begin
            // Branch target is computed speculatively for every instruction.
            ctrl_o.alu_src_b = SRCB_IMM_SH2;
            ctrl_o.alu_op    = ALU_OP_ADD;
            ctrl_o.retire    = nop_i;
         end
         S_EX_R: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_src_b = SRCB_B;
            ctrl_o.alu_op    = ALU_OP_FUNCT;
         end
         S_EX_I: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_src_b = SRCB_IMM;
            ctrl_o.alu_op    = slti_i ? ALU_OP_SLT : ALU_OP_ADD;
         end
         S_MADDR: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_src_b = SRCB_IMM;
            ctrl_o.alu_op    = ALU_OP_ADD;
         end
         S_MRD: begin
            ctrl_o.iord     = 1'b1;
            ctrl_o.mem_read = 1'b1;
         end
         S_MWR: begin
            ctrl_o.iord      = 1'b1;
            ctrl_o.mem_write = 1'b1;
            ctrl_o.retire    = mem_ready_i;
         end
         S_WB_R: begin
            ctrl_o.reg_write = 1'b1;
            ctrl_o.reg_dst   = 1'b1;
            ctrl_o.retire    = 1'b1;
         end
         S_WB_I: begin
            ctrl_o.reg_write = 1'b1;
            ctrl_o.retire    = 1'b1;
         end
         S_WB_M: begin
            ctrl_o.reg_write  = 1'b1;
            ctrl_o.mem_to_reg = 1'b1;
            ctrl_o.retire     = 1'b1;
         end
         S_BR: begin
            ctrl_o.alu_src_a     = 1'b1;
            ctrl_o.alu_src_b     = SRCB_B;
            ctrl_o.alu_op        = ALU_OP_SUB;
            ctrl_o.pc_write_cond = 1'b1;
            ctrl_o.pc_source     = 1'b1;
            ctrl_o.retire        = 1'b1;
         end
         default: ctrl_o = '0;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM (IF/ID/EX/MEM/WB) with memory-ready handshake.
// Define MC_ILLEGAL_TRAP_EN to trap unknown opcodes (adds illegal_o).
module multicycle_ctrl
   import mc_pkg::*;
#(
   parameter int OP_W    = 6,
   parameter int STATE_W = 4
)
(
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [OP_W-1:0]    opcode_i,
   input  logic               mem_ready_i,
   output logic               pc_write_o,
   output logic               pc_write_cond_o,
   output logic               pc_source_o,
   output logic               iord_o,
   output logic               mem_read_o,
   output logic               mem_write_o,
   output logic               ir_write_o,
   output logic               reg_dst_o,
   output logic               mem_to_reg_o,
   output logic               reg_write_o,
   output logic               alu_src_a_o,
   output logic [1:0]         alu_src_b_o,
   output logic [1:0]         alu_op_o,
   output logic               retire_o,
`ifdef MC_ILLEGAL_TRAP_EN
   output logic               illegal_o,
`endif
   output logic [STATE_W-1:0] state_o
);

   logic [3:0] state_q, state_d;
   logic       slti_q, slti_d;
   logic [5:0] op;
   logic       nop;
   ctrl_t      ctrl;
   ctrl_t      ctrl_gated;

   assign op = 6'(opcode_i);

`ifdef MC_ILLEGAL_TRAP_EN
   assign nop = 1'b0;
`else
   assign nop = (state_q == S_ID) && !is_known_op(op);
`endif

   always_comb begin
      state_d = state_q;
      slti_d  = slti_q;
      case (state_q)
         S_IF:    if (mem_ready_i) state_d = S_ID;
         S_ID: begin
            // EX_I cannot see the opcode, so ADDI vs SLTI is latched here.
            slti_d = (op == OP_SLTI);
            case (op)
               OP_R:             state_d = S_EX_R;
               OP_ADDI, OP_SLTI: state_d = S_EX_I;
               OP_LW, OP_SW:     state_d = S_MADDR;
               OP_BEQ:           state_d = S_BR;
`ifdef MC_ILLEGAL_TRAP_EN
               default:          state_d = S_TRAP;
`else
               default:          state_d = S_IF;
`endif
            endcase
         end
         S_EX_R:  state_d = S_WB_R;
         S_EX_I:  state_d = S_WB_I;
         S_MADDR: state_d = (op == OP_LW) ? S_MRD : S_MWR;
         S_MRD:   if (mem_ready_i) state_d = S_WB_M;
         S_MWR:   if (mem_ready_i) state_d = S_IF;
`ifdef MC_ILLEGAL_TRAP_EN
         S_TRAP:  state_d = S_TRAP;
`endif
         default: state_d = S_IF;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q <= S_IF;
         slti_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         slti_q  <= slti_d;
      end
   end

   mc_out_decode u_out_decode (
      .state_i     (state_q),
      .mem_ready_i (mem_ready_i),
      .slti_i      (slti_q),
      .nop_i       (nop),
      .ctrl_o      (ctrl)
   );

   // Outputs are forced quiet for the whole time reset is asserted.
   assign ctrl_gated = rst_i ? ctrl : '0;

   assign pc_write_o      = ctrl_gated.pc_write;
   assign pc_write_cond_o = ctrl_gated.pc_write_cond;
   assign pc_source_o     = ctrl_gated.pc_source;
   assign iord_o          = ctrl_gated.iord;
   assign mem_read_o      = ctrl_gated.mem_read;
   assign mem_write_o     = ctrl_gated.mem_write;
   assign ir_write_o      = ctrl_gated.ir_write;
   assign reg_dst_o       = ctrl_gated.reg_dst;
   assign mem_to_reg_o    = ctrl_gated.mem_to_reg;
   assign reg_write_o     = ctrl_gated.reg_write;
   assign alu_src_a_o     = ctrl_gated.alu_src_a;
   assign alu_src_b_o     = ctrl_gated.alu_src_b;
   assign alu_op_o        = ctrl_gated.alu_op;
   assign retire_o        = ctrl_gated.retire;
   assign state_o         = rst_i ? STATE_W'(state_q) : '0;
`ifdef MC_ILLEGAL_TRAP_EN
   assign illegal_o       = rst_i && (state_q == S_TRAP);
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction cycle plans built
// from the instruction-level behaviour, randomized waits and don't-care inputs.
module tb_multicycle_ctrl;

   localparam logic [5:0] T_R    = 6'h00;
   localparam logic [5:0] T_ADDI = 6'h08;
   localparam logic [5:0] T_SLTI = 6'h0A;
   localparam logic [5:0] T_LW   = 6'h23;
   localparam logic [5:0] T_SW   = 6'h2B;
   localparam logic [5:0] T_BEQ  = 6'h04;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       pc_source;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       retire;
   } ctl_t;

   typedef struct packed {
      ctl_t exp;
      logic rdy;
      logic drive_op;
      logic in_fetch;
   } step_t;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic [5:0] opcode_i;
   logic       mem_ready_i;
   logic       pc_write_o, pc_write_cond_o, pc_source_o, iord_o;
   logic       mem_read_o, mem_write_o, ir_write_o, reg_dst_o;
   logic       mem_to_reg_o, reg_write_o, alu_src_a_o, retire_o;
   logic [1:0] alu_src_b_o, alu_op_o;
   logic [3:0] state_o;
`ifdef MC_ILLEGAL_TRAP_EN
   logic       illegal_o;
`endif

   ctl_t  act;
   step_t plan_q[$];
   int    checks   = 0;
   int    failures = 0;

   always #5 clk_i = ~clk_i;

   multicycle_ctrl #(.OP_W(6), .STATE_W(4)) dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .opcode_i        (opcode_i),
      .mem_ready_i     (mem_ready_i),
      .pc_write_o      (pc_write_o),
      .pc_write_cond_o (pc_write_cond_o),
      .pc_source_o     (pc_source_o),
      .iord_o          (iord_o),
      .mem_read_o      (mem_read_o),
      .mem_write_o     (mem_write_o),
      .ir_write_o      (ir_write_o),
      .reg_dst_o       (reg_dst_o),
      .mem_to_reg_o    (mem_to_reg_o),
      .reg_write_o     (reg_write_o),
      .alu_src_a_o     (alu_src_a_o),
      .alu_src_b_o     (alu_src_b_o),
      .alu_op_o        (alu_op_o),
      .retire_o        (retire_o),
`ifdef MC_ILLEGAL_TRAP_EN
      .illegal_o       (illegal_o),
`endif
      .state_o         (state_o)
   );

   assign act = {pc_write_o, pc_write_cond_o, pc_source_o, iord_o, mem_read_o,
                 mem_write_o, ir_write_o, reg_dst_o, mem_to_reg_o, reg_write_o,
                 alu_src_a_o, alu_src_b_o, alu_op_o, retire_o};

   function automatic logic known(input logic [5:0] op);
      return op == T_R || op == T_ADDI || op == T_SLTI ||
             op == T_LW || op == T_SW || op == T_BEQ;
   endfunction

   function automatic logic rnd();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic [5:0] rand_illegal();
      logic [5:0] o;
      do o = 6'($urandom); while (known(o));
      return o;
   endfunction

   // Retire cycle index (1-based) from instruction class and wait counts.
   function automatic int latency(input logic [5:0] op, input int w_if, input int w_mem);
      if (op == T_BEQ) return 3 + w_if;
      if (op == T_LW)  return 5 + w_if + w_mem;
      if (op == T_SW)  return 4 + w_if + w_mem;
      if (known(op))   return 4 + w_if;
      return 2 + w_if;
   endfunction

   function automatic ctl_t k_fetch(input logic rdy);
      ctl_t c = '0;
      c.mem_read  = 1'b1;
      c.alu_src_b = 2'b01;
      c.ir_write  = rdy;
      c.pc_write  = rdy;
      return c;
   endfunction

   function automatic ctl_t k_decode(input logic nop);
      ctl_t c = '0;
      c.alu_src_b = 2'b11;
      c.retire    = nop;
      return c;
   endfunction

   function automatic ctl_t k_alu(input logic [1:0] srcb, input logic [1:0] aop);
      ctl_t c = '0;
      c.alu_src_a = 1'b1;
      c.alu_src_b = srcb;
      c.alu_op    = aop;
      return c;
   endfunction

   function automatic ctl_t k_mem(input logic wr, input logic rdy);
      ctl_t c = '0;
      c.iord      = 1'b1;
      c.mem_read  = !wr;
      c.mem_write = wr;
      c.retire    = wr && rdy;
      return c;
   endfunction

   function automatic ctl_t k_wb(input logic dst, input logic m2r);
      ctl_t c = '0;
      c.reg_write  = 1'b1;
      c.reg_dst    = dst;
      c.mem_to_reg = m2r;
      c.retire     = 1'b1;
      return c;
   endfunction

   function automatic ctl_t k_br();
      ctl_t c = '0;
      c.alu_src_a     = 1'b1;
      c.alu_op        = 2'b01;
      c.pc_write_cond = 1'b1;
      c.pc_source     = 1'b1;
      c.retire        = 1'b1;
      return c;
   endfunction

   function automatic void push(input ctl_t c, input logic rdy, input logic drv, input logic f);
      plan_q.push_back({c, rdy, drv, f});
   endfunction

   // Expected cycle-by-cycle plan for one instruction.
   function automatic void plan(input logic [5:0] op, input int w_if, input int w_mem);
      plan_q.delete();
      for (int i = 0; i < w_if; i++) push(k_fetch(1'b0), 1'b0, 1'b0, 1'b1);
      push(k_fetch(1'b1), 1'b1, 1'b0, 1'b1);
      if (!known(op)) begin
`ifdef MC_ILLEGAL_TRAP_EN
         push(k_decode(1'b0), rnd(), 1'b1, 1'b0);
         for (int i = 0; i < 5; i++) push('0, rnd(), 1'b0, 1'b0);
`else
         push(k_decode(1'b1), rnd(), 1'b1, 1'b0);
`endif
      end else begin
         push(k_decode(1'b0), rnd(), 1'b1, 1'b0);
         case (op)
            T_R: begin
               push(k_alu(2'b00, 2'b10), rnd(), 1'b0, 1'b0);
               push(k_wb(1'b1, 1'b0), rnd(), 1'b0, 1'b0);
            end
            T_ADDI, T_SLTI: begin
               push(k_alu(2'b10, (op == T_SLTI) ? 2'b11 : 2'b00), rnd(), 1'b0, 1'b0);
               push(k_wb(1'b0, 1'b0), rnd(), 1'b0, 1'b0);
            end
            T_LW, T_SW: begin
               push(k_alu(2'b10, 2'b00), rnd(), 1'b1, 1'b0);
               for (int i = 0; i < w_mem; i++) push(k_mem(op == T_SW, 1'b0), 1'b0, 1'b0, 1'b0);
               push(k_mem(op == T_SW, 1'b1), 1'b1, 1'b0, 1'b0);
               if (op == T_LW) push(k_wb(1'b0, 1'b1), rnd(), 1'b0, 1'b0);
            end
            default: push(k_br(), rnd(), 1'b0, 1'b0);
         endcase
      end
   endfunction

   task automatic run_plan(input logic [5:0] op, input int limit,
                           output int ret_cycle, output int n_ret);
      step_t e;
      int    idx = 0;
      ret_cycle = 0;
      n_ret     = 0;
      while (plan_q.size() > 0 && idx < limit) begin
         e = plan_q.pop_front();
         @(negedge clk_i);
         mem_ready_i = e.rdy;
         opcode_i    = e.drive_op ? op : 6'($urandom);
         #1;
         idx++;
         checks++;
         if (act !== e.exp) begin
            failures++;
            $display("FAIL ctrl op=%02h cycle=%0d got=%04h expected=%04h", op, idx, act, e.exp);
         end
         checks++;
         if (e.in_fetch ? (state_o !== 4'd0) : (state_o === 4'd0)) begin
            failures++;
            $display("FAIL state op=%02h cycle=%0d got=%0d expected_fetch=%0b", op, idx, state_o, e.in_fetch);
         end
         if (retire_o === 1'b1) begin
            n_ret++;
            ret_cycle = idx;
         end
      end
      plan_q.delete();
   endtask

   task automatic test_reset();
      rst_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i);
         mem_ready_i = rnd();
         opcode_i    = 6'($urandom);
         #1;
         checks++;
         if (act !== '0 || state_o !== 4'd0) begin
            failures++;
            $display("FAIL reset_quiet got=%04h state=%0d required=0000 state=0", act, state_o);
         end
      end
      @(negedge clk_i);
      rst_i       = 1'b1;
      mem_ready_i = 1'b0;
      #1;
      checks++;
      if (act !== k_fetch(1'b0) || state_o !== 4'd0) begin
         failures++;
         $display("FAIL reset_release got=%04h state=%0d required=%04h state=0", act, state_o, k_fetch(1'b0));
      end
   endtask

   task automatic test_single(input logic [5:0] op, input int w_if, input int w_mem);
      int rc, nr;
      plan(op, w_if, w_mem);
      run_plan(op, 100, rc, nr);
      checks++;
      if (rc !== latency(op, w_if, w_mem) || nr !== 1) begin
         failures++;
         $display("FAIL latency op=%02h retire_cycle=%0d retires=%0d required=%0d,1", op, rc, nr, latency(op, w_if, w_mem));
      end
   endtask

   task automatic test_reset_mid_mrd();
      int rc, nr;
      plan(T_LW, 0, 3);
      run_plan(T_LW, 5, rc, nr);
      @(negedge clk_i);
      rst_i       = 1'b0;
      mem_ready_i = 1'b1;
      #1;
      checks++;
      if (act !== '0 || state_o !== 4'd0) begin
         failures++;
         $display("FAIL mrd_reset_quiet got=%04h state=%0d required=0000 state=0", act, state_o);
      end
      @(negedge clk_i);
      rst_i       = 1'b1;
      mem_ready_i = 1'b0;
      #1;
      checks++;
      if (state_o !== 4'd0 || mem_read_o !== 1'b1 || iord_o !== 1'b0 || act !== k_fetch(1'b0)) begin
         failures++;
         $display("FAIL mrd_reset_to_if got=%04h state=%0d required=%04h state=0", act, state_o, k_fetch(1'b0));
      end
   endtask

   task automatic test_illegal();
      int rc, nr;
      plan(6'h3F, 0, 0);
      run_plan(6'h3F, 100, rc, nr);
`ifdef MC_ILLEGAL_TRAP_EN
      checks++;
      if (illegal_o !== 1'b1 || nr !== 0) begin
         failures++;
         $display("FAIL trap_sticky illegal=%0b retires=%0d required=1,0", illegal_o, nr);
      end
      @(negedge clk_i);
      rst_i = 1'b0;
      #1;
      checks++;
      if (illegal_o !== 1'b0 || act !== '0) begin
         failures++;
         $display("FAIL trap_reset illegal=%0b ctrl=%04h required=0,0000", illegal_o, act);
      end
      @(negedge clk_i);
      rst_i       = 1'b1;
      mem_ready_i = 1'b0;
      #1;
      checks++;
      if (state_o !== 4'd0 || act !== k_fetch(1'b0)) begin
         failures++;
         $display("FAIL trap_exit state=%0d ctrl=%04h required=0,%04h", state_o, act, k_fetch(1'b0));
      end
`else
      checks++;
      if (rc !== 2 || nr !== 1) begin
         failures++;
         $display("FAIL nop_retire retire_cycle=%0d retires=%0d required=2,1", rc, nr);
      end
`endif
   endtask

   task automatic test_back_to_back();
      logic [5:0] ops[7];
      logic [5:0] op;
      ops = '{T_R, T_ADDI, T_SLTI, T_LW, T_SW, T_BEQ, 6'h3F};
      for (int n = 0; n < 40; n++) begin
`ifdef MC_ILLEGAL_TRAP_EN
         op = ops[$urandom_range(0, 5)];
`else
         op = ops[$urandom_range(0, 6)];
         if (op == 6'h3F) op = rand_illegal();
`endif
         test_single(op, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
      end
   endtask

   initial begin
      rst_i       = 1'b0;
      mem_ready_i = 1'b0;
      opcode_i    = 6'h00;
      test_reset();
      test_single(T_R, 0, 0);
      test_single(T_LW, 0, 2);
      test_single(T_SW, 0, 0);
      test_single(T_BEQ, 0, 0);
      test_single(T_SLTI, 1, 0);
      test_single(T_ADDI, 0, 0);
      test_reset_mid_mrd();
      test_single(T_SW, 2, 3);
      test_illegal();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
